// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L2 CPU-side arbiter.
package l2_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LINE_W = 256;

   typedef enum logic [2:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      RESP_I,
      RESP_D
   } arb_state_t;

   typedef enum logic {
      REQ_I,
      REQ_D
   } req_id_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: one cycle from inc to value, sticks at all-ones.
// No backpressure; inc is ignored once saturated.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] value
);

   localparam logic [W-1:0] ONE = W'(1);
   localparam logic [W-1:0] MAX = {W{1'b1}};

   always_ff @(posedge clk) begin
      if (rst)
         value <= '0;
      else if (inc && (value != MAX))
         value <= value + ONE;
   end

endmodule

// File: rtl/l2_arbiter.sv
// Two-requester (I/D) arbiter holding one latched transaction on the L2 port.
// Command one cycle after request; requesters hold until their resp pulse.
module l2_arbiter
   import l2_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int LINE_W       = DEF_LINE_W,
   parameter bit FIXED_D_PRIO = 1'b0,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp,
   output logic [CNT_W-1:0]  conflicts
);

   arb_state_t        state, state_nxt;
   req_id_t           rr_last, rr_last_nxt;
   logic              read_nxt, write_nxt, i_resp_nxt, d_resp_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [LINE_W-1:0] wdata_nxt, i_rdata_nxt, d_rdata_nxt;
   logic              i_req, d_req, pick_d, conflict;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_last  <= REQ_D;
         l2_read  <= 1'b0;
         l2_write <= 1'b0;
         l2_addr  <= '0;
         l2_wdata <= '0;
         i_rdata  <= '0;
         d_rdata  <= '0;
         i_resp   <= 1'b0;
         d_resp   <= 1'b0;
      end else begin
         state    <= state_nxt;
         rr_last  <= rr_last_nxt;
         l2_read  <= read_nxt;
         l2_write <= write_nxt;
         l2_addr  <= addr_nxt;
         l2_wdata <= wdata_nxt;
         i_rdata  <= i_rdata_nxt;
         d_rdata  <= d_rdata_nxt;
         i_resp   <= i_resp_nxt;
         d_resp   <= d_resp_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      rr_last_nxt = rr_last;
      read_nxt    = l2_read;
      write_nxt   = l2_write;
      addr_nxt    = l2_addr;
      wdata_nxt   = l2_wdata;
      i_rdata_nxt = i_rdata;
      d_rdata_nxt = d_rdata;
      i_resp_nxt  = 1'b0;
      d_resp_nxt  = 1'b0;
      pick_d      = 1'b0;
      conflict    = 1'b0;

      case (state)
         IDLE: begin
            if (i_req && d_req) begin
               conflict = 1'b1;
               pick_d   = FIXED_D_PRIO ? 1'b1 : (rr_last == REQ_I);
            end else begin
               pick_d   = d_req;
            end
            if (i_req || d_req) begin
               if (pick_d) begin
                  // Write wins if both D strobes are (illegally) high.
                  state_nxt = GRANT_D;
                  addr_nxt  = d_addr;
                  wdata_nxt = d_wdata;
                  write_nxt = d_write;
                  read_nxt  = d_read & ~d_write;
               end else begin
                  state_nxt = GRANT_I;
                  addr_nxt  = i_addr;
                  read_nxt  = 1'b1;
                  write_nxt = 1'b0;
               end
            end
         end
         GRANT_I: begin
            if (l2_resp) begin
               state_nxt   = RESP_I;
               i_rdata_nxt = l2_rdata;
               i_resp_nxt  = 1'b1;
               read_nxt    = 1'b0;
               write_nxt   = 1'b0;
               rr_last_nxt = REQ_I;
            end
         end
         GRANT_D: begin
            if (l2_resp) begin
               state_nxt   = RESP_D;
               d_rdata_nxt = l2_rdata;
               d_resp_nxt  = 1'b1;
               read_nxt    = 1'b0;
               write_nxt   = 1'b0;
               rr_last_nxt = REQ_D;
            end
         end
         RESP_I, RESP_D: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   sat_counter #(
      .W (CNT_W)
   ) u_conflicts (
      .clk   (clk),
      .rst   (rst),
      .inc   (conflict),
      .value (conflicts)
   );

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench: unit 0 is round-robin with a 4-bit counter, unit 1 is fixed D priority.
module tb_l2_arbiter;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_read   [2];
   logic [31:0]  i_addr   [2];
   logic [255:0] i_rdata  [2];
   logic         i_resp   [2];
   logic         d_read   [2];
   logic         d_write  [2];
   logic [31:0]  d_addr   [2];
   logic [255:0] d_wdata  [2];
   logic [255:0] d_rdata  [2];
   logic         d_resp   [2];
   logic         l2_read  [2];
   logic         l2_write [2];
   logic [31:0]  l2_addr  [2];
   logic [255:0] l2_wdata [2];
   logic [255:0] l2_rdata [2];
   logic         l2_resp  [2];
   logic [3:0]   conf4;
   logic [15:0]  conf16;
   logic [15:0]  conf     [2];

   int checks = 0;
   int errors = 0;

   assign conf[0] = {12'b0, conf4};
   assign conf[1] = conf16;

   always #5 clk = ~clk;

   l2_arbiter #(.ADDR_W(32), .LINE_W(256), .FIXED_D_PRIO(1'b0), .CNT_W(4)) u_rr (
      .clk(clk), .rst(rst),
      .i_read(i_read[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
      .d_read(d_read[0]), .d_write(d_write[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
      .l2_read(l2_read[0]), .l2_write(l2_write[0]), .l2_addr(l2_addr[0]), .l2_wdata(l2_wdata[0]),
      .l2_rdata(l2_rdata[0]), .l2_resp(l2_resp[0]), .conflicts(conf4)
   );

   l2_arbiter #(.ADDR_W(32), .LINE_W(256), .FIXED_D_PRIO(1'b1), .CNT_W(16)) u_fix (
      .clk(clk), .rst(rst),
      .i_read(i_read[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
      .d_read(d_read[1]), .d_write(d_write[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
      .l2_read(l2_read[1]), .l2_write(l2_write[1]), .l2_addr(l2_addr[1]), .l2_wdata(l2_wdata[1]),
      .l2_rdata(l2_rdata[1]), .l2_resp(l2_resp[1]), .conflicts(conf16)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Invariants on every cycle out of reset.
   always @(negedge clk) begin
      if (!rst) begin
         for (int u = 0; u < 2; u++) begin
            check("one_cmd", 256'(l2_read[u] & l2_write[u]), 256'd0);
            check("one_resp", 256'(i_resp[u] & d_resp[u]), 256'd0);
            check("d_rd_wr_illegal", 256'(d_read[u] & d_write[u]), 256'd0);
         end
      end
   end

   // Both ports request in one cycle; first_d says which must be served first.
   task automatic tie_round(input int u, input logic first_d);
      logic [255:0] line_a, line_b;
      line_a = {8{32'h1111_0000 + 32'(u)}};
      line_b = {8{32'h2222_0000 + 32'(u)}};
      i_read[u] = 1'b1; i_addr[u] = 32'h3000;
      d_read[u] = 1'b1; d_addr[u] = 32'h4000;
      tick();
      check("tie_first_cmd", 256'(l2_read[u]), 256'd1);
      check("tie_first_addr", 256'(l2_addr[u]), first_d ? 256'h4000 : 256'h3000);
      l2_resp[u] = 1'b1; l2_rdata[u] = line_a;
      tick();
      l2_resp[u] = 1'b0;
      if (first_d) begin
         check("tie_first_dresp", 256'(d_resp[u]), 256'd1);
         check("tie_first_drdata", d_rdata[u], line_a);
         d_read[u] = 1'b0;
      end else begin
         check("tie_first_iresp", 256'(i_resp[u]), 256'd1);
         check("tie_first_irdata", i_rdata[u], line_a);
         i_read[u] = 1'b0;
      end
      tick();
      tick();
      check("tie_second_cmd", 256'(l2_read[u]), 256'd1);
      check("tie_second_addr", 256'(l2_addr[u]), first_d ? 256'h3000 : 256'h4000);
      l2_resp[u] = 1'b1; l2_rdata[u] = line_b;
      tick();
      l2_resp[u] = 1'b0;
      if (first_d) begin
         check("tie_second_iresp", 256'(i_resp[u]), 256'd1);
         check("tie_second_irdata", i_rdata[u], line_b);
         i_read[u] = 1'b0;
      end else begin
         check("tie_second_dresp", 256'(d_resp[u]), 256'd1);
         check("tie_second_drdata", d_rdata[u], line_b);
         d_read[u] = 1'b0;
      end
      tick();
   endtask

   initial begin
      logic [255:0] a5_line, wline, wline2, dline, late_line;
      a5_line   = {32{8'hA5}};
      wline     = {8{32'h1234_5678}};
      wline2    = {8{32'hCAFE_F00D}};
      dline     = {8{32'h0BAD_BEEF}};
      late_line = {8{32'hDEAD_0001}};
      for (int u = 0; u < 2; u++) begin
         i_read[u] = 1'b0; i_addr[u] = '0; d_read[u] = 1'b0; d_write[u] = 1'b0;
         d_addr[u] = '0; d_wdata[u] = '0; l2_rdata[u] = '0; l2_resp[u] = 1'b0;
      end
      tick();
      tick();
      rst = 1'b0;

      check("rst_l2_read", 256'(l2_read[0]), 256'd0);
      check("rst_l2_write", 256'(l2_write[0]), 256'd0);
      check("rst_l2_addr", 256'(l2_addr[0]), 256'd0);
      check("rst_l2_wdata", l2_wdata[0], 256'd0);
      check("rst_i_resp", 256'(i_resp[0]), 256'd0);
      check("rst_d_resp", 256'(d_resp[0]), 256'd0);
      check("rst_conflicts", 256'(conf[0]), 256'd0);

      // I-only read, L2 answers three cycles after the command appears.
      i_read[0] = 1'b1; i_addr[0] = 32'h0000_1000;
      tick();
      check("i_cmd_t1", 256'(l2_read[0]), 256'd1);
      check("i_addr_t1", 256'(l2_addr[0]), 256'h1000);
      check("i_nowrite", 256'(l2_write[0]), 256'd0);
      tick();
      tick();
      check("i_cmd_held", 256'(l2_read[0]), 256'd1);
      tick();
      l2_resp[0] = 1'b1; l2_rdata[0] = a5_line;
      tick();
      l2_resp[0] = 1'b0; l2_rdata[0] = '0;
      check("i_resp_pulse", 256'(i_resp[0]), 256'd1);
      check("i_rdata", i_rdata[0], a5_line);
      check("i_no_dresp", 256'(d_resp[0]), 256'd0);
      check("i_cmd_cleared", 256'(l2_read[0]), 256'd0);
      tick();
      i_read[0] = 1'b0;
      check("i_resp_one_cycle", 256'(i_resp[0]), 256'd0);
      check("i_rdata_hold", i_rdata[0], a5_line);
      tick();
      check("i_stale_not_regranted", 256'(l2_read[0]), 256'd0);

      // D write with address/data toggled while granted.
      d_write[0] = 1'b1; d_addr[0] = 32'h0000_2040; d_wdata[0] = wline;
      tick();
      check("d_write_cmd", 256'(l2_write[0]), 256'd1);
      check("d_write_noread", 256'(l2_read[0]), 256'd0);
      check("d_write_addr", 256'(l2_addr[0]), 256'h2040);
      check("d_write_wdata", l2_wdata[0], wline);
      d_addr[0] = 32'hFFFF_FFC0; d_wdata[0] = wline2;
      tick();
      d_write[0] = 1'b0;
      tick();
      d_write[0] = 1'b1;
      check("d_addr_held", 256'(l2_addr[0]), 256'h2040);
      check("d_wdata_held", l2_wdata[0], wline);
      check("d_cmd_held", 256'(l2_write[0]), 256'd1);
      l2_resp[0] = 1'b1; l2_rdata[0] = dline;
      tick();
      l2_resp[0] = 1'b0;
      check("d_resp_pulse", 256'(d_resp[0]), 256'd1);
      check("d_no_iresp", 256'(i_resp[0]), 256'd0);
      check("d_write_cleared", 256'(l2_write[0]), 256'd0);
      d_write[0] = 1'b0;
      tick();
      check("d_resp_one_cycle", 256'(d_resp[0]), 256'd0);
      tick();
      check("d_idle_noread", 256'(l2_read[0]), 256'd0);
      check("d_no_conflict", 256'(conf[0]), 256'd0);

      // Round-robin ties: I first both times since rr_last ends on D.
      tie_round(0, 1'b0);
      check("rr_conf_1", 256'(conf[0]), 256'd1);
      tie_round(0, 1'b0);
      check("rr_conf_2", 256'(conf[0]), 256'd2);

      // Fixed D priority: D first both times.
      tie_round(1, 1'b1);
      tie_round(1, 1'b1);
      check("fix_conf_2", 256'(conf[1]), 256'd2);

      // 21 conflict IDLE cycles on the 4-bit counter: must stick at 15.
      i_read[0] = 1'b1; d_read[0] = 1'b1; l2_resp[0] = 1'b1;
      for (int k = 0; k < 63; k++) tick();
      i_read[0] = 1'b0; d_read[0] = 1'b0; l2_resp[0] = 1'b0;
      tick();
      check("sat_conflicts", 256'(conf[0]), 256'd15);
      tick();
      check("sat_no_wrap", 256'(conf[0]), 256'd15);

      // Reset during GRANT_D abandons the transaction.
      d_read[0] = 1'b1; d_addr[0] = 32'h0000_5000;
      tick();
      check("rst_pre_cmd", 256'(l2_read[0]), 256'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; d_read[0] = 1'b0;
      check("midrst_l2_read", 256'(l2_read[0]), 256'd0);
      check("midrst_l2_addr", 256'(l2_addr[0]), 256'd0);
      check("midrst_d_resp", 256'(d_resp[0]), 256'd0);
      check("midrst_i_rdata", i_rdata[0], 256'd0);
      check("midrst_d_rdata", d_rdata[0], 256'd0);
      check("midrst_conflicts", 256'(conf[0]), 256'd0);
      l2_resp[0] = 1'b1; l2_rdata[0] = late_line;
      tick();
      l2_resp[0] = 1'b0;
      tick();
      check("late_no_dresp", 256'(d_resp[0]), 256'd0);
      check("late_d_rdata", d_rdata[0], 256'd0);
      check("late_no_cmd", 256'(l2_read[0]), 256'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-requester arbiter that sits directly upstream of the L2 cache controller.
- Merges I-cache and D-cache miss traffic (256-bit line reads, D-cache line writebacks) onto the single L2 CPU-side port.
- Holds one transaction at a time, latched stable until the L2 responds, because the L2 controller samples its request lines across multiple states.
- Resolves simultaneous requests round-robin (or fixed D-priority) and counts contention events.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, cacheline width in bits.
- FIXED_D_PRIO, 0, 1 = D-cache always wins ties; 0 = round-robin.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_read  in  1  I-cache line read request, held until i_resp.
- i_addr  in  ADDR_W  I-cache line address.
- i_rdata  out  LINE_W  line returned to I-cache, valid while i_resp=1.
- i_resp  out  1  one-cycle completion pulse to I-cache.
- d_read  in  1  D-cache line read request, held until d_resp.
- d_write  in  1  D-cache line write request, held until d_resp.
- d_addr  in  ADDR_W  D-cache line address.
- d_wdata  in  LINE_W  D-cache write line.
- d_rdata  out  LINE_W  line returned to D-cache, valid while d_resp=1.
- d_resp  out  1  one-cycle completion pulse to D-cache.
- l2_read  out  1  read command to L2.
- l2_write  out  1  write command to L2.
- l2_addr  out  ADDR_W  latched request address.
- l2_wdata  out  LINE_W  latched write line.
- l2_rdata  in  LINE_W  L2 read data, valid with l2_resp.
- l2_resp  in  1  L2 completion, single-cycle pulse.
- conflicts  out  CNT_W  saturating count of IDLE cycles with both requesters active.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE.
  - All outputs 0: i_resp, d_resp, l2_read, l2_write, l2_addr, l2_wdata, i_rdata, d_rdata, conflicts.
  - rr_last = D, so I wins the first tie.
  - Reset mid-transaction abandons it with no resp pulse; the L2 sees its command drop the next cycle.
- States: IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D. All outputs are registered.
- IDLE:
  - Only I requesting -> GRANT_I.
  - Only D requesting (d_read|d_write) -> GRANT_D.
  - Both requesting: FIXED_D_PRIO=1 -> GRANT_D; otherwise the requester that is not rr_last wins. conflicts += 1, saturating at all-ones (no wrap).
  - On the transition, latch the winner's addr into l2_addr; for D, latch d_wdata into l2_wdata.
  - Set l2_read/l2_write from the next cycle. I sets l2_read=1. D sets l2_write=d_write and l2_read=d_read&~d_write.
  - d_read&d_write both high is illegal; write wins, and the bench asserts this never occurs.
- GRANT_x:
  - Commands and latched addr/wdata are held constant regardless of requester inputs; requester drops are ignored.
  - On l2_resp: capture l2_rdata into x_rdata, clear l2_read/l2_write, set rr_last=x, go to RESP_x.
  - Without l2_resp, stay indefinitely (no timeout).
- RESP_x:
  - x_resp=1 for exactly one cycle; the other resp stays 0. Then -> IDLE.
  - Requests are not sampled in RESP_x, so the requester's stale request on the pulse cycle is never re-granted.
- x_rdata holds its value after the pulse until the next capture.
- Latency:
  - Request first high at cycle t (state IDLE) -> L2 command visible from t+1.
  - l2_resp at cycle r -> x_resp at r+1 -> IDLE at r+2.
  - A pending request from the other port is granted with its command visible at r+3.
- An l2_resp arriving outside GRANT_x is ignored; no state change and no data capture.
- Exactly one of l2_read/l2_write is ever high. i_resp and d_resp are never high together.

Decomposition:
- Package l2_arb_pkg holds the state enum (arb_state_t), the requester enum (req_id_t {REQ_I, REQ_D}), and default LINE_W/ADDR_W constants.
- One natural sub-module: sat_counter (parameter W; inc in; value out; synchronous reset; saturates at 2^W-1). Used for conflicts.

Test Plan:
- I-only read of 0x0000_1000, L2 responds 3 cycles after the command with 0xA5..A5:
  - l2_read=1 with l2_addr=0x1000 from t+1.
  - i_resp pulses 1 cycle with i_rdata=0xA5..A5; d_resp stays 0.
- D write of 0x0000_2040 with wdata=0x1234..., d_addr toggled mid-grant:
  - l2_write=1 with l2_addr=0x2040 held stable, unaffected by the toggle.
  - d_resp pulses once; l2_read never asserts.
- I and D requests raised in the same cycle, twice, with FIXED_D_PRIO=0:
  - First round: I, then D.
  - Second round: again I then D, because rr_last=D after the D service.
  - conflicts=2.
- Same as the previous scenario with FIXED_D_PRIO=1 -> D granted first in both rounds.
- Force 2^CNT_W+5 conflict cycles with CNT_W=4 -> conflicts sticks at 15.
- rst asserted during GRANT_D with l2_resp pending:
  - Next cycle all outputs are 0 and no d_resp pulse.
  - A late l2_resp in IDLE is ignored; d_rdata stays 0.
